mips_cpu_mem_port: RTL and testbench
====================================

Name: mips_cpu_mem_port

Overview:
Parametrised multi-channel Avalon-MM master port for the multicycle CPU. It arbitrates NUM_CH requesters (e.g. fetch, load/store, debug) onto one Avalon bus and generates byteenable and lane-aligned write data for byte, half and word accesses. It extracts and sign- or zero-extends read data, and reports misaligned accesses without issuing a bus cycle. It sits between the CPU datapath/controller and the top-level bus pins.

Parameters:
NUM_CH, 2, number of requester channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, bus data width; 32 or 64; BE_W = DATA_W/8

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel accept; one-hot or zero
req_write  in  NUM_CH  1 = store, 0 = load
req_signed  in  NUM_CH  sign-extend load result
req_size  in  2*NUM_CH  0 = byte, 1 = half, 2 = word, 3 = dword (legal only if DATA_W=64)
req_addr  in  ADDR_W*NUM_CH  byte address
req_wdata  in  DATA_W*NUM_CH  store data, right-justified
rsp_valid  out  NUM_CH  one-cycle completion pulse, one-hot
rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
mem_address  out  ADDR_W  aligned address (low log2(BE_W) bits zero)
memread  out  1  Avalon read
memwrite  out  1  Avalon write
waitrequest  in  1  Avalon stall
memwritedata  out  DATA_W  lane-replicated store data
byteenable  out  BE_W  active lanes
memreaddata  in  DATA_W  valid in the cycle memread=1 and waitrequest=0

Behaviour:
- Reset: state IDLE; rr_ptr=NUM_CH-1. All outputs are 0: req_ready, rsp_valid, rsp_err, rsp_rdata, memread, memwrite, mem_address, memwritedata, byteenable.
- A reset asserted mid-transaction abandons it. No rsp_valid is produced. memread/memwrite are 0 from the next edge.
- FSM states: IDLE, BUS, RESP.
- IDLE: grant = first valid channel searching from rr_ptr+1 modulo NUM_CH. req_ready[grant] is high combinationally. Accept = valid & ready.
  - On accept: latch the request and set rr_ptr = grant.
  - Aligned and legal: go to BUS.
  - Misaligned or illegal size: go to RESP with err=1. No bus cycle is issued.
- BUS: memread/memwrite, mem_address, byteenable and memwritedata are registered and held constant while waitrequest=1.
  - On the first cycle with waitrequest=0: capture memreaddata (reads), drop memread/memwrite at the next edge, go to RESP.
  - No timeout.
- RESP: for one cycle, rsp_valid[ch]=1 with rsp_err and rsp_rdata. Then go to IDLE. req_ready is 0 during BUS and RESP.
- Latency:
  - Accept at cycle 0; bus command visible from cycle 1.
  - With zero wait states, rsp_valid is at cycle 2. Each waitrequest cycle adds 1.
  - Error response is at cycle 1.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0.
- Lanes are little-endian: lane k = byte offset k within the aligned word. byteenable covers 2^size bytes starting at the offset.
- Write data is replicated: byte ×BE_W, half ×BE_W/2, word ×BE_W/4.
- Reads: shift the selected lanes to bit 0. Extend from bit 8·2^size−1: sign extension if req_signed, zero extension otherwise. A full-width access ignores req_signed.
- Only one transaction is outstanding. memread and memwrite are never high simultaneously.
- A channel dropping req_valid before accept is legal. Requests are not pipelined.

Decomposition:
- Package mips_cpu_mem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD)
  - port_state_t enum (IDLE, BUS, RESP)
  - function is_aligned(addr, size)
- Sub-module mips_cpu_mem_lane (combinational, parametrised by DATA_W) produces byteenable, replicated write data and extended read data from offset, size and signed. It is instantiated once in the port.

Test Plan:
- Ch0 word read at 0x100, waitrequest high 2 cycles, memreaddata=0x12345678 -> memread held 3 cycles, address 0x100 stable, rsp_valid[0] at cycle 4, rsp_rdata=0x12345678, rsp_err=0.
- Signed byte load at 0x103, memreaddata=0x80AABBCC -> byteenable=1000, rsp_rdata=0xFFFFFF80; same with req_signed=0 -> 0x00000080.
- Half store at 0x206, wdata=0x0000BEEF -> mem_address=0x204, byteenable=1100, memwritedata=0xBEEFBEEF, memwrite one cycle with waitrequest=0.
- Ch0 and ch1 both requesting continuously -> grants alternate 0,1,0,1; neither starves; rr_ptr wraps correctly with NUM_CH=3.
- Half load at 0x301 -> no memread/memwrite, rsp_valid at cycle 1, rsp_err=1, rsp_rdata=0.
- Reset asserted during BUS with waitrequest=1 -> memread=0 after that edge, no rsp_valid, next request starts cleanly from IDLE.

Source files
------------

// File: rtl/mips_cpu_mem_pkg.sv
// Shared types and helpers for the CPU Avalon-MM memory port.
package mips_cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } port_state_t;

    function automatic logic is_aligned(input logic [2:0] addr_lo, input size_t size);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (addr_lo[0] == 1'b0);
            SZ_WORD: ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_cpu_mem_lane.sv
// Byte-lane steering: byteenable, replicated store data and extended load data.
module mips_cpu_mem_lane
    import mips_cpu_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [OFF_W-1:0]  offset,
    input  size_t             size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] wdata_lanes,
    output logic [DATA_W-1:0] rdata_ext
);

    localparam int IDX_W = $clog2(DATA_W);

    logic [7:0]        lane_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic [IDX_W-1:0]  sign_idx;
    logic              sign_bit;
    int unsigned       ext_bits;

    always_comb begin
        lane_mask   = 8'h00;
        wdata_lanes = '0;
        ext_bits    = 8;
        case (size)
            SZ_BYTE: begin
                lane_mask   = 8'h01;
                wdata_lanes = {BE_W{wdata[7:0]}};
                ext_bits    = 8;
            end
            SZ_HALF: begin
                lane_mask   = 8'h03;
                wdata_lanes = {(BE_W/2){wdata[15:0]}};
                ext_bits    = 16;
            end
            SZ_WORD: begin
                lane_mask   = 8'h0F;
                wdata_lanes = {(BE_W/4){wdata[31:0]}};
                ext_bits    = 32;
            end
            default: begin
                lane_mask   = 8'hFF;
                wdata_lanes = wdata;
                ext_bits    = 64;
            end
        endcase
        if (ext_bits > DATA_W)
            ext_bits = DATA_W;

        byteenable = BE_W'(lane_mask) << offset;

        // Full-width accesses keep every bit, so sign_bit never reaches the result.
        shifted    = rdata >> {offset, 3'b000};
        sign_idx   = IDX_W'(ext_bits - 1);
        sign_bit   = is_signed & shifted[sign_idx];
        keep       = {DATA_W{1'b1}} >> (DATA_W - ext_bits);
        rdata_ext  = (shifted & keep) | ({DATA_W{sign_bit}} & ~keep);
    end

endmodule

// File: rtl/mips_cpu_mem_port.sv
// Round-robin multi-channel Avalon-MM master port for the multicycle CPU.
module mips_cpu_mem_port
    import mips_cpu_mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH-1:0]        req_signed,
    input  logic [2*NUM_CH-1:0]      req_size,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [DATA_W*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     memread,
    output logic                     memwrite,
    input  logic                     waitrequest,
    output logic [DATA_W-1:0]        memwritedata,
    output logic [DATA_W/8-1:0]      byteenable,
    input  logic [DATA_W-1:0]        memreaddata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    port_state_t state, state_next;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   lat_ch;
    logic              lat_write;
    logic              lat_signed;
    logic              lat_err;
    size_t             lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_raw;

    logic              grant_found;
    int unsigned       grant_int;
    size_t             sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ok;
    logic              accept;

    logic [BE_W-1:0]   lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;

    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_int   = 0;
        idx         = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_CH;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_int   = idx;
            end
        end
    end

    assign sel_size = size_t'(req_size[grant_int*2 +: 2]);
    assign sel_addr = req_addr[grant_int*ADDR_W +: ADDR_W];
    assign sel_ok   = ((sel_size != SZ_DWORD) || (DATA_W == 64))
                      && is_aligned(sel_addr[2:0], sel_size);
    assign accept   = (state == IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = sel_ok ? BUS : RESP;
            BUS:     if (!waitrequest) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= CH_W'(NUM_CH - 1);
            lat_ch     <= '0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_raw  <= '0;
        end else begin
            if (accept) begin
                rr_ptr     <= CH_W'(grant_int);
                lat_ch     <= CH_W'(grant_int);
                lat_write  <= req_write[grant_int];
                lat_signed <= req_signed[grant_int];
                lat_err    <= !sel_ok;
                lat_size   <= sel_size;
                lat_addr   <= sel_addr;
                lat_wdata  <= req_wdata[grant_int*DATA_W +: DATA_W];
            end
            if (state == BUS && !waitrequest && !lat_write)
                rdata_raw <= memreaddata;
        end
    end

    mips_cpu_mem_lane #(
        .DATA_W(DATA_W)
    ) u_lane (
        .offset      (lat_addr[OFF_W-1:0]),
        .size        (lat_size),
        .is_signed   (lat_signed),
        .wdata       (lat_wdata),
        .rdata       (rdata_raw),
        .byteenable  (lane_be),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    // Bus and response outputs decode from registered state only, so they hold through stalls.
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        mem_address  = '0;
        byteenable   = '0;
        memwritedata = '0;
        if (accept)
            req_ready = NUM_CH'(1) << grant_int;
        case (state)
            BUS: begin
                memread      = !lat_write;
                memwrite     = lat_write;
                mem_address  = {lat_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                byteenable   = lane_be;
                memwritedata = lat_write ? lane_wdata : '0;
            end
            RESP: begin
                rsp_valid = NUM_CH'(1) << lat_ch;
                rsp_err   = lat_err;
                rsp_rdata = (lat_err || lat_write) ? '0 : lane_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_mem_port.sv
// Directed self-checking bench for mips_cpu_mem_port (3 channels, 32-bit bus).
module tb_mips_cpu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_write;
    logic [2:0]  req_signed;
    logic [5:0]  req_size;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address;
    logic        memread;
    logic        memwrite;
    logic        waitrequest;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic [31:0] memreaddata;

    int checks   = 0;
    int failures = 0;

    mips_cpu_mem_port #(
        .NUM_CH(3),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_signed   (req_signed),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_address  (mem_address),
        .memread      (memread),
        .memwrite     (memwrite),
        .waitrequest  (waitrequest),
        .memwritedata (memwritedata),
        .byteenable   (byteenable),
        .memreaddata  (memreaddata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic sg, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[ch]        = 1'b1;
        req_write[ch]        = wr;
        req_signed[ch]       = sg;
        req_size[ch*2 +: 2]  = sz;
        req_addr[ch*32 +: 32]  = a;
        req_wdata[ch*32 +: 32] = wd;
    endtask

    // Zero-wait transaction: accept, one bus cycle, response.
    task automatic xfer(input string tag, input int ch, input logic wr, input logic sg,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
        set_req(ch, wr, sg, sz, a, wd);
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'(3'b001 << ch));
        next_cycle();
        req_valid   = '0;
        memreaddata = rd;
        #1;
        check({tag, ".memread"}, 64'(memread), 64'(!wr));
        check({tag, ".memwrite"}, 64'(memwrite), 64'(wr));
        check({tag, ".addr"}, 64'(mem_address), 64'(exp_addr));
        check({tag, ".be"}, 64'(byteenable), 64'(exp_be));
        check({tag, ".wdata"}, 64'(memwritedata), 64'(exp_wd));
        next_cycle();
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(3'b001 << ch));
        check({tag, ".rsp_err"}, 64'(rsp_err), 64'(0));
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        check({tag, ".bus_idle"}, 64'({memread, memwrite}), 64'(0));
        next_cycle();
    endtask

    task automatic rr_grant(input string tag, input logic [2:0] exp_oh, input logic [31:0] exp_addr);
        int n = 0;
        while (req_ready == 3'b000 && n < 8) begin
            next_cycle();
            n++;
        end
        check({tag, ".ready"}, 64'(req_ready), 64'(exp_oh));
        next_cycle();
        check({tag, ".addr"}, 64'(mem_address), 64'(exp_addr));
        next_cycle();
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_signed  = '0;
        req_size    = '0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        memreaddata = '0;
        repeat (3) next_cycle();
        check("rst.ready", 64'(req_ready), 64'(0));
        check("rst.rsp", 64'({rsp_valid, rsp_err}), 64'(0));
        check("rst.rdata", 64'(rsp_rdata), 64'(0));
        check("rst.bus", 64'({memread, memwrite, byteenable}), 64'(0));
        check("rst.addr", 64'(mem_address), 64'(0));
        check("rst.wdata", 64'(memwritedata), 64'(0));
        reset = 1'b0;
        next_cycle();

        // Word read with two wait states
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        waitrequest = 1'b1;
        #1;
        check("wr2.ready", 64'(req_ready), 64'(3'b001));
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            req_valid = '0;
            if (c == 3) begin
                waitrequest = 1'b0;
                memreaddata = 32'h12345678;
            end
            #1;
            check("wr2.memread", 64'(memread), 64'(1));
            check("wr2.addr", 64'(mem_address), 64'h100);
            check("wr2.rsp_early", 64'(rsp_valid), 64'(0));
        end
        next_cycle();
        check("wr2.rsp_valid", 64'(rsp_valid), 64'(3'b001));
        check("wr2.rsp_err", 64'(rsp_err), 64'(0));
        check("wr2.rdata", 64'(rsp_rdata), 64'h12345678);
        check("wr2.memread_off", 64'(memread), 64'(0));
        next_cycle();

        xfer("lbs", 0, 1'b0, 1'b1, 2'd0, 32'h103, 32'h0, 32'h80AABBCC,
             32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        xfer("lbu", 0, 1'b0, 1'b0, 2'd0, 32'h103, 32'h0, 32'h80AABBCC,
             32'h100, 4'b1000, 32'h0, 32'h00000080);
        xfer("sh", 1, 1'b1, 1'b0, 2'd1, 32'h206, 32'h0000BEEF, 32'h0,
             32'h204, 4'b1100, 32'hBEEFBEEF, 32'h0);
        xfer("sb", 2, 1'b1, 1'b0, 2'd0, 32'h101, 32'h123456A5, 32'h0,
             32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
        xfer("lhs", 1, 1'b0, 1'b1, 2'd1, 32'h102, 32'h0, 32'h80011234,
             32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
        xfer("lws", 0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h87654321,
             32'h0, 4'b1111, 32'h0, 32'h87654321);

        // Misaligned half and illegal dword: immediate error, no bus cycle
        set_req(0, 1'b0, 1'b0, 2'd1, 32'h301, 32'h0);
        #1;
        check("mis.ready", 64'(req_ready), 64'(3'b001));
        next_cycle();
        req_valid = '0;
        #1;
        check("mis.bus", 64'({memread, memwrite}), 64'(0));
        check("mis.rsp_valid", 64'(rsp_valid), 64'(3'b001));
        check("mis.rsp_err", 64'(rsp_err), 64'(1));
        check("mis.rdata", 64'(rsp_rdata), 64'(0));
        next_cycle();
        set_req(2, 1'b0, 1'b0, 2'd3, 32'h400, 32'h0);
        #1;
        next_cycle();
        req_valid = '0;
        #1;
        check("dw.bus", 64'({memread, memwrite}), 64'(0));
        check("dw.rsp", 64'({rsp_valid, rsp_err}), 64'({3'b100, 1'b1}));
        next_cycle();

        // Reset while stalled in BUS abandons the transaction
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h500, 32'h0);
        waitrequest = 1'b1;
        #1;
        next_cycle();
        req_valid = '0;
        #1;
        check("rbus.memread", 64'(memread), 64'(1));
        reset = 1'b1;
        next_cycle();
        check("rbus.memread_off", 64'(memread), 64'(0));
        check("rbus.rsp", 64'(rsp_valid), 64'(0));
        reset       = 1'b0;
        waitrequest = 1'b0;
        next_cycle();
        check("rbus.rsp_after", 64'(rsp_valid), 64'(0));

        // Round-robin: ch0/ch1 alternate, then all three wrap through ch2
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
        #1;
        rr_grant("rr0", 3'b001, 32'h10);
        rr_grant("rr1", 3'b010, 32'h20);
        rr_grant("rr2", 3'b001, 32'h10);
        rr_grant("rr3", 3'b010, 32'h20);
        set_req(2, 1'b0, 1'b0, 2'd2, 32'h30, 32'h0);
        #1;
        rr_grant("rr4", 3'b100, 32'h30);
        rr_grant("rr5", 3'b001, 32'h10);
        rr_grant("rr6", 3'b010, 32'h20);
        rr_grant("rr7", 3'b100, 32'h30);
        req_valid = '0;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
